snapshot_scheduler: RTL

Controller that sequences a free-running count datapath and its storage register: it starts, stops and clears a WIDTH-bit counter and issues periodic save strobes that capture the count into a snapshot register. Captured snapshots go to a consumer over a valid/ack handshake, and samples dropped while the consumer is busy are flagged. It sits between the counter/storage datapath and whatever logic reads timestamps. It replaces the free-toggling `save` stimulus with deterministic scheduling.

---
 rtl/snapshot_scheduler_if.sv | 25 ++
 rtl/snapshot_scheduler.sv | 104 ++++++++++
 2 files changed

// File: rtl/snapshot_scheduler_if.sv
// Handshake bundle between the snapshot scheduler and its controller/consumer.
// The master drives run control and ack; the slave (the scheduler) drives count and snapshot state.
interface snapshot_scheduler_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] period;
  logic             ack;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] snap_data;
  logic             snap_valid;
  logic             overrun;
  logic             busy;

  modport master (
    output start, stop, period, ack,
    input  count, snap_data, snap_valid, overrun, busy
  );

  modport slave (
    input  start, stop, period, ack,
    output count, snap_data, snap_valid, overrun, busy
  );
endinterface

// File: rtl/snapshot_scheduler.sv
// Runs a free-running counter and captures it into a snapshot register every period+1 run cycles.
// Snapshots are handed off over valid/ack; saves that land on a pending snapshot set a sticky overrun.
module snapshot_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  snapshot_scheduler_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] intv_q, intv_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] snap_data_q, snap_data_d;
  logic             snap_valid_q, snap_valid_d;
  logic             overrun_q, overrun_d;
  logic             save;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_d      = state_q;
    count_d      = count_q;
    intv_d       = intv_q;
    period_d     = period_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    overrun_d    = overrun_q;
    save         = 1'b0;

    case (state_q)
      IDLE: ;
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          count_d = count_q + 1'b1;
          if (intv_q == period_q) begin
            save   = 1'b1;
            intv_d = '0;
          end else begin
            intv_d = intv_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture uses the pre-increment count; an ack on the save edge frees the slot for it.
    if (save) begin
      if (!snap_valid_q || bus.ack) begin
        snap_data_d  = count_q;
        snap_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus.ack && snap_valid_q) begin
      snap_valid_d = 1'b0;
    end

    // Start wins over stop, a coincident save and any handshake activity.
    if (bus.start) begin
      state_d      = RUN;
      count_d      = '0;
      intv_d       = '0;
      period_d     = bus.period;
      snap_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      intv_q       <= '0;
      period_q     <= '0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      intv_q       <= intv_d;
      period_q     <= period_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.snap_data  = snap_data_q;
  assign bus.snap_valid = snap_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q == RUN);

endmodule
